// File: rtl/csr_counter_bank_pkg.sv
// csr_counter_bank_pkg: CSR address map, CSR operation encoding and
// mcountinhibit bit positions shared by the counter bank and its users.
package csr_counter_bank_pkg;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'b00,
    CSR_OP_SET   = 2'b01,
    CSR_OP_CLEAR = 2'b10,
    CSR_OP_NONE  = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPM_BASE      = 12'hC03;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
  localparam logic [11:0] CSR_HI_OFS        = 12'h080;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  // Masking out the counter index and high-half bit leaves the region base
  localparam logic [11:0] CSR_CNT_MASK      = 12'hF60;

  localparam int unsigned INH_CY   = 0;
  localparam int unsigned IDX_TIME = 1;
  localparam int unsigned INH_IR   = 2;
  localparam int unsigned INH_HPM0 = 3;

  function automatic logic [31:0] inhibit_mask(input int unsigned nh);
    logic [31:0] m;
    m = '0;
    m[INH_CY] = 1'b1;
    m[INH_IR] = 1'b1;
    for (int unsigned i = 0; i < nh; i++) m[INH_HPM0 + i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_counter_bank_if.sv
// csr_counter_bank_if: CSR access path between the instruction pipeline
// (master) and the counter bank (slave).
interface csr_counter_bank_if;
  import csr_counter_bank_pkg::*;

  logic [11:0] sel;
  csr_op_t     op;
  logic [31:0] din;
  logic        we;
  logic [31:0] dout;
  logic        illegal;

  modport master (output sel, op, din, we, input dout, illegal);
  modport slave  (input sel, op, din, we, output dout, illegal);
endinterface

// File: rtl/csr_counter.sv
// csr_counter: one W-bit counter with inhibitable increment and independent
// low/high 32-bit half writes; a write in a cycle suppresses that increment.
module csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          inhibit,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [31:0]   wdata,
  output logic [W-1:0]  value
);
  logic [63:0] merged;

  // Merge at 64 bits then truncate, so high-half bits >= W drop out
  always_comb begin
    merged = 64'(value);
    if (we_lo) merged[31:0]  = wdata;
    if (we_hi) merged[63:32] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                value <= '0;
    else if (we_lo || we_hi)   value <= W'(merged);
    else if (inc && !inhibit)  value <= value + W'(1);
  end
endmodule

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: cycle/time/instret/hpm counters with zero-latency CSR
// reads and CSRRW/CSRRS/CSRRC writes. hpm counters exist only with CSR_HPM_EN.
module csr_counter_bank
  import csr_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned TIME_DIV  = 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic                                     instret_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  csr_counter_bank_if.slave                        csr
);
`ifdef CSR_HPM_EN
  localparam int unsigned NH     = NUM_HPM;
  localparam bit          HPM_EN = 1'b1;
`else
  localparam int unsigned NH     = 0;
  localparam bit          HPM_EN = 1'b0;
  logic hpm_unused;
  assign hpm_unused = ^hpm_event_i;
`endif
  localparam logic [31:0] INH_MASK = inhibit_mask(NH);
  localparam int unsigned PW       = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  logic [CNT_WIDTH-1:0] cnt [32];
  logic [31:0] inhibit_q, rd, wval;
  logic [63:0] sel_val;
  logic [PW-1:0] presc;
  logic [4:0] idx;
  logic hi, ro, rw, inh_sel, cnt_impl, cnt_zero, cnt_ok;
  logic wr_req, illegal, wr_en, wr_cnt, wr_inh, time_tick;

  always_comb begin
    idx      = csr.sel[4:0];
    hi       = |(csr.sel & CSR_HI_OFS);
    ro       = (csr.sel & CSR_CNT_MASK) == CSR_CYCLE;
    rw       = (csr.sel & CSR_CNT_MASK) == CSR_MCYCLE;
    inh_sel  = csr.sel == CSR_MCOUNTINHIBIT;
    cnt_impl = {27'd0, idx} < INH_HPM0 + NH;
    // Without hpm storage the whole hpm window is a legal hardwired zero
    cnt_zero = !HPM_EN && ({27'd0, idx} >= INH_HPM0);
    cnt_ok   = (ro || rw) && (cnt_impl || cnt_zero) && !(rw && {27'd0, idx} == IDX_TIME);
    wr_req   = csr.we && (csr.op != CSR_OP_NONE);
    illegal  = !(inh_sel || cnt_ok) || (wr_req && ro && !cnt_zero);

    sel_val = 64'(cnt[idx]);
    rd = '0;
    if (inh_sel)                  rd = inhibit_q;
    else if (cnt_ok && cnt_impl)  rd = hi ? sel_val[63:32] : sel_val[31:0];

    wval = rd;
    case (csr.op)
      CSR_OP_WRITE: wval = csr.din;
      CSR_OP_SET:   wval = rd | csr.din;
      CSR_OP_CLEAR: wval = rd & ~csr.din;
      default:      wval = rd;
    endcase

    wr_en  = wr_req && !illegal;
    wr_cnt = wr_en && rw && cnt_impl;
    wr_inh = wr_en && inh_sel;
  end

  assign csr.dout    = rd;
  assign csr.illegal = illegal;
  assign time_tick   = (presc == PW'(TIME_DIV - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) presc <= '0;
    else           presc <= time_tick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)   inhibit_q <= '0;
    else if (wr_inh) inhibit_q <= wval & INH_MASK;
  end

  for (genvar k = 0; k < 32; k++) begin : g_cnt
    if (k == IDX_TIME) begin : g_time
      csr_counter #(.W(CNT_WIDTH)) u_cnt (
        .clk(clk_i), .rst_n(reset_ni), .inc(time_tick), .inhibit(1'b0),
        .we_lo(1'b0), .we_hi(1'b0), .wdata('0), .value(cnt[k])
      );
    end else if (k < INH_HPM0 + NH) begin : g_ctr
      logic inc;
      if (k == INH_CY)      begin : g_cy  assign inc = 1'b1;                        end
      else if (k == INH_IR) begin : g_ir  assign inc = instret_i;                   end
      else                  begin : g_hpm assign inc = hpm_event_i[k - INH_HPM0];   end
      csr_counter #(.W(CNT_WIDTH)) u_cnt (
        .clk(clk_i), .rst_n(reset_ni), .inc(inc), .inhibit(inhibit_q[k]),
        .we_lo(wr_cnt && !hi && (idx == 5'(k))),
        .we_hi(wr_cnt && hi && (idx == 5'(k))),
        .wdata(wval), .value(cnt[k])
      );
    end else begin : g_zero
      assign cnt[k] = '0;
    end
  end
endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank: directed and randomized checks of csr_counter_bank
// against an arithmetic reference model of the counter rules.
module tb_csr_counter_bank;
  import csr_counter_bank_pkg::*;

  localparam int unsigned NH = 4;
  localparam int unsigned CW = 40;
  localparam int unsigned TD = 4;
`ifdef CSR_HPM_EN
  localparam bit HPM = 1'b1;
`else
  localparam bit HPM = 1'b0;
`endif
  localparam longint unsigned WMASK = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instret;
  logic [NH-1:0] hpm_ev;

  csr_counter_bank_if bus ();

  csr_counter_bank #(.NUM_HPM(NH), .CNT_WIDTH(CW), .TIME_DIV(TD)) dut (
    .clk_i(clk), .reset_ni(rst_n), .instret_i(instret),
    .hpm_event_i(hpm_ev), .csr(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference state: counters by index, cycles since reset (time derives from it)
  longint unsigned m_cnt [32];
  longint unsigned m_n;
  logic [31:0]     m_inh;

  function automatic void mdl_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_n   = 0;
    m_inh = '0;
  endfunction

  function automatic void decode(input logic [11:0] a, output bit ro, output bit rw,
                                 output bit hi, output int k);
    ro = 0; rw = 0; hi = 0; k = -1;
    if (a >= 12'hC00 && a <= 12'hC1F)      begin ro = 1; k = int'(a) - 'hC00; end
    else if (a >= 12'hC80 && a <= 12'hC9F) begin ro = 1; hi = 1; k = int'(a) - 'hC80; end
    else if (a >= 12'hB00 && a <= 12'hB1F) begin rw = 1; k = int'(a) - 'hB00; end
    else if (a >= 12'hB80 && a <= 12'hB9F) begin rw = 1; hi = 1; k = int'(a) - 'hB80; end
  endfunction

  function automatic bit impl(input int k);
    return k >= 0 && (k < 3 || (HPM && k < 3 + int'(NH)));
  endfunction

  function automatic bit hard0(input int k);
    return !HPM && k >= 3;
  endfunction

  function automatic bit mapped(input logic [11:0] a);
    bit ro, rw, hi; int k;
    decode(a, ro, rw, hi, k);
    if (a == 12'h320) return 1'b1;
    if (!(ro || rw)) return 1'b0;
    if (rw && k == 1) return 1'b0;
    return impl(k) || hard0(k);
  endfunction

  function automatic logic [31:0] exp_dout(input logic [11:0] a);
    bit ro, rw, hi; int k;
    longint unsigned v;
    decode(a, ro, rw, hi, k);
    if (a == 12'h320) return m_inh;
    if (!mapped(a) || !impl(k)) return 32'h0;
    v = (k == 1) ? ((m_n / TD) & WMASK) : m_cnt[k];
    return hi ? v[63:32] : v[31:0];
  endfunction

  function automatic logic exp_illegal(input logic [11:0] a, input logic w, input csr_op_t o);
    bit ro, rw, hi; int k;
    decode(a, ro, rw, hi, k);
    return !mapped(a) || (w && o != CSR_OP_NONE && ro && !hard0(k));
  endfunction

  function automatic logic [31:0] mdl_inh_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int i = 0; i < int'(NH); i++) if (HPM) m[3 + i] = 1'b1;
    return m;
  endfunction

  function automatic void mdl_clock();
    bit ro, rw, hi, ev; int k, wk;
    logic [31:0] old, nv, new_inh;
    if (!rst_n) return;
    decode(bus.sel, ro, rw, hi, k);
    wk = -1;
    new_inh = m_inh;
    if (bus.we && bus.op != CSR_OP_NONE && !exp_illegal(bus.sel, bus.we, bus.op)) begin
      old = exp_dout(bus.sel);
      case (bus.op)
        CSR_OP_WRITE: nv = bus.din;
        CSR_OP_SET:   nv = old | bus.din;
        default:      nv = old & ~bus.din;
      endcase
      if (bus.sel == 12'h320) new_inh = nv & mdl_inh_mask();
      else if (rw && impl(k)) begin
        wk = k;
        if (hi) m_cnt[k] = ((longint'(nv) << 32) | (m_cnt[k] & 64'hFFFF_FFFF)) & WMASK;
        else    m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | longint'(nv);
      end
    end
    for (int i = 0; i < 32; i++) begin
      if (i == 1 || !impl(i)) continue;
      ev = (i == 0) ? 1'b1 : (i == 2) ? instret : hpm_ev[i - 3];
      if (ev && !m_inh[i] && i != wk) m_cnt[i] = (m_cnt[i] + 1) & WMASK;
    end
    m_inh = new_inh;
    m_n++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s sel=%h: observed %h expected %h", tag, bus.sel, got, exp);
  endtask

  task automatic model_chk();
    chk("dout", bus.dout, exp_dout(bus.sel));
    chk("illegal", {31'd0, bus.illegal}, {31'd0, exp_illegal(bus.sel, bus.we, bus.op)});
  endtask

  // Drive one cycle's inputs just after the falling edge and check reads
  task automatic setup(input logic [11:0] a, input csr_op_t o, input logic [31:0] d,
                       input logic w, input logic ir, input logic [NH-1:0] ev);
    @(negedge clk);
    bus.sel = a; bus.op = o; bus.din = d; bus.we = w;
    instret = ir; hpm_ev = ev;
    #1;
    model_chk();
  endtask

  task automatic look(input logic [11:0] a);
    bus.sel = a;
    #1;
    model_chk();
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_clock();
  endtask

  task automatic idle(input logic [11:0] a, input logic ir);
    setup(a, CSR_OP_NONE, 32'h0, 1'b0, ir, '0);
  endtask

  logic [11:0] addrs [24] = '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC06, 12'hC07,
                              12'hC1F, 12'hC80, 12'hC81, 12'hC82, 12'hC83, 12'hB00,
                              12'hB01, 12'hB02, 12'hB03, 12'hB06, 12'hB07, 12'hB80,
                              12'hB81, 12'hB82, 12'hB83, 12'h320, 12'h7FF, 12'hC86};

  initial begin
    longint unsigned snap_cy, snap_ir;
    logic [31:0] exp5;
    bit ro, rw, hi; int k;
    logic [11:0] a;
    logic w;

    rst_n = 1'b0; instret = 1'b0; hpm_ev = '0;
    bus.sel = 12'hC00; bus.op = CSR_OP_NONE; bus.din = '0; bus.we = 1'b0;
    mdl_reset();

    // Reset state, then 10 counting clocks with TIME_DIV = 4
    idle(12'hC00, 1'b0); chk("rst_cycle", bus.dout, 32'h0);
    tick();
    idle(12'hC01, 1'b0); chk("rst_time", bus.dout, 32'h0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin idle(12'hC00, 1'b0); tick(); end
    idle(12'hC00, 1'b0); chk("cycle10", bus.dout, 32'd10);
    look(12'hC01);       chk("time2", bus.dout, 32'd2);
    look(12'hC02);       chk("instret0", bus.dout, 32'd0);
    tick();

    // Low-half write then high-half write; carry into high half on next clock
    setup(12'hB00, CSR_OP_WRITE, 32'hFFFF_FFFF, 1'b1, 1'b0, '0); tick();
    setup(12'hB80, CSR_OP_WRITE, 32'h0, 1'b1, 1'b0, '0); tick();
    idle(12'hC00, 1'b0); chk("cyc_nowrap_during_wr", bus.dout, 32'hFFFF_FFFF);
    tick();
    idle(12'hC00, 1'b0); chk("cyc_lo_carry", bus.dout, 32'h0);
    look(12'hC80);       chk("cyc_hi_carry", bus.dout, 32'h1);
    tick();

    // 40-bit instret wrap
    setup(12'hB82, CSR_OP_WRITE, 32'hFFFF_FFFF, 1'b1, 1'b0, '0); tick();
    setup(12'hB02, CSR_OP_WRITE, 32'hFFFF_FFFF, 1'b1, 1'b0, '0); tick();
    idle(12'hC82, 1'b0); chk("ir_hi_trunc", bus.dout, 32'hFF);
    look(12'hC02);       chk("ir_lo_full", bus.dout, 32'hFFFF_FFFF);
    tick();
    idle(12'hC02, 1'b1); tick();
    idle(12'hC02, 1'b0); chk("ir_lo_wrap", bus.dout, 32'h0);
    look(12'hC82);       chk("ir_hi_wrap", bus.dout, 32'h0);
    tick();

    // mcountinhibit freezes cycle and instret, CLEAR releases cycle only
    setup(12'h320, CSR_OP_WRITE, 32'h5, 1'b1, 1'b0, '0); tick();
    idle(12'h320, 1'b1); chk("inh_rd5", bus.dout, 32'h5);
    snap_cy = m_cnt[0]; snap_ir = m_cnt[2];
    tick();
    for (int i = 0; i < 4; i++) begin idle(12'hC00, 1'b1); tick(); end
    idle(12'hC00, 1'b1); chk("cy_frozen", bus.dout, 32'(snap_cy));
    look(12'hC02);       chk("ir_frozen", bus.dout, 32'(snap_ir));
    tick();
    setup(12'h320, CSR_OP_CLEAR, 32'h1, 1'b1, 1'b1, '0); tick();
    idle(12'hC00, 1'b1); chk("cy_still_held", bus.dout, 32'(snap_cy));
    tick();
    idle(12'hC00, 1'b1); chk("cy_resumed", bus.dout, 32'(snap_cy + 1));
    look(12'hC02);       chk("ir_still_frozen", bus.dout, 32'(snap_ir));
    look(12'h320);       chk("inh_rd4", bus.dout, 32'h4);
    tick();

    // hpm: count events, then SET collides with an event (write wins)
    for (int i = 0; i < 3; i++) begin setup(12'hC03, CSR_OP_NONE, 32'h0, 1'b0, 1'b0, 4'b0001); tick(); end
    setup(12'hB03, CSR_OP_SET, 32'h100, 1'b1, 1'b0, 4'b0001);
    exp5 = HPM ? (32'(m_cnt[3]) | 32'h100) : 32'h0;
    tick();
    idle(12'hC03, 1'b0); chk("hpm_set_wins", bus.dout, exp5);
    tick();

    // Illegal accesses change nothing
    setup(12'hC00, CSR_OP_WRITE, 32'h1234, 1'b1, 1'b0, '0);
    chk("ro_write_illegal", {31'd0, bus.illegal}, 32'h1);
    tick();
    idle(12'h7FF, 1'b0);
    chk("unmapped_illegal", {31'd0, bus.illegal}, 32'h1);
    chk("unmapped_dout", bus.dout, 32'h0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = addrs[$urandom_range(0, 23)];
      w = ($urandom_range(0, 2) == 0);
      decode(a, ro, rw, hi, k);
      if (ro && k >= 3) w = 1'b0;
      setup(a, csr_op_t'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom),
            w, 1'($urandom_range(0, 1)), NH'($urandom));
      tick();
    end

    // Asynchronous reset mid-count, then restart from zero
    idle(12'hC00, 1'b1);
    rst_n = 1'b0; mdl_reset();
    #1; chk("async_rst_cycle", bus.dout, 32'h0);
    look(12'hC01); chk("async_rst_time", bus.dout, 32'h0);
    look(12'h320); chk("async_rst_inh", bus.dout, 32'h0);
    tick();
    idle(12'hC02, 1'b1); chk("rst_held_ir", bus.dout, 32'h0);
    rst_n = 1'b1;
    tick();
    idle(12'hC00, 1'b0); chk("restart_cycle", bus.dout, 32'h1);
    look(12'hC02);       chk("restart_ir", bus.dout, 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csr_counter_bank.md
# csr_counter_bank

Parametrised counter/CSR unit replacing the fixed cycle/time/instret CSR block in the core's execute stage. It provides cycle, time, instret and NUM_HPM hardware performance counters of configurable width, plus machine-mode write access, CSRRW/CSRRS/CSRRC semantics, a time prescaler, per-counter inhibit (mcountinhibit) and illegal-access flagging. It is read combinationally by the CSR instruction path and updated on the clock edge.

## Interface
- NUM_HPM, 4, number of mhpmcounter3.. implemented (0..29)
- CNT_WIDTH, 64, counter width in bits (33..64)
- TIME_DIV, 1, clk_i cycles per time tick (>=1)
- clk_i  in  1  clock
- reset_ni  in  1  reset; one clock, asynchronous, active-low
- sel_i  in  12  CSR address
- op_i  in  2  csr_op_t: CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR, CSR_OP_NONE
- din_i  in  32  write operand (rs1/uimm)
- we_i  in  1  commit the CSR operation this cycle
- instret_i  in  1  one instruction retired this cycle
- hpm_event_i  in  NUM_HPM  per-counter increment strobes
- dout_o  out  32  current (pre-write) value of sel_i
- illegal_o  out  1  sel_i unimplemented, or we_i to a read-only address

## Operation
- Address map: 0xC00 cycle, 0xC01 time, 0xC02 instret, 0xC03+i hpmcounter, 0xC80/0xC81/0xC82/0xC83+i high halves (all read-only); 0xB00 mcycle, 0xB02 minstret, 0xB03+i mhpmcounter, 0xB80/0xB82/0xB83+i high halves (RW aliases of the same counters); 0x320 mcountinhibit (RW).
- Low-half address returns bits [31:0]; high half returns bits [CNT_WIDTH-1:32] zero-extended.
- Write value: WRITE -> din_i; SET -> old | din_i; CLEAR -> old & ~din_i; NONE -> no write.
- Write to a half replaces only that half; bits >= CNT_WIDTH are discarded.
- Increment: cycle +1 each clock; instret +1 when instret_i; hpm[i] +1 when hpm_event_i[i]; each gated by its mcountinhibit bit (bit0 CY, bit2 IR, bit3+i HPM).
- time: prescaler counts 0..TIME_DIV-1, time +1 on wrap; not inhibitable, not writable (no 0xB01).
- mcountinhibit: bits 0, 2, 3..3+NUM_HPM-1 writable; all others read zero.
- Wrap: counter at 2^CNT_WIDTH-1 increments to 0 silently.
- Simultaneous write and increment to the same counter: write wins, no increment that cycle (either half).
- illegal_o is high for unmapped addresses regardless of we_i, and for we_i with op_i != NONE on 0xC-range addresses; illegal accesses change no state; dout_o = 0 for unmapped.

## Timing
- dout_o, illegal_o combinational from sel_i/op_i/we_i and current state; zero-latency read.
- Writes and increments take effect at the next rising clk_i; a read in cycle N+1 sees a write from cycle N.
- Inhibit takes effect from the cycle after the mcountinhibit write.
- reset_ni low: all counters, prescaler, mcountinhibit = 0 immediately; dout_o = 0 for every address; illegal_o still reflects decoding. Reset deasserted mid-run restarts counting from 0 on the first clock after release.

## Configuration
- CSR_HPM_EN defined: NUM_HPM hpm counters, events and inhibit bits exist as above.
- Not defined: no hpm storage; 0xC03-0xC1F, 0xC83-0xC9F, 0xB03-0xB1F, 0xB83-0xB9F read zero, writes ignored, illegal_o = 0 (hardwired-zero); hpm_event_i ignored; mcountinhibit bits 3+ read zero.

## Structure
- Package definitions: CSR address constants (cycle/time/instret/hpm base, high offsets, mcountinhibit), csr_op_t enum, inhibit bit indices.
- Sub-module csr_counter: one CNT_WIDTH counter with inc, inhibit, write-low/write-high enables and write data; instantiated for cycle, instret and each hpm (generate loop). time uses it with inhibit tied low.

## Test plan
- Reset, run 10 clocks, TIME_DIV=4 -> cycle 0xC00 reads 10, time 0xC01 reads 2, instret 0.
- Write mcycle 0xB00 = 0xFFFFFFFF, 0xB80 = 0 then clock -> 0xC00 reads 0x00000000, 0xC80 reads 1 (carry).
- CNT_WIDTH=40: write 0xB82 = 0xFFFFFFFF, 0xB02 = 0xFFFFFFFF, pulse instret_i -> 0xC02 = 0, 0xC82 = 0 (wrap), high half read 0xFF before pulse.
- Write mcountinhibit 0x320 = 0x5, hold 5 clocks with instret_i=1 -> cycle and instret unchanged; CLEAR 0x1 -> cycle resumes, instret still frozen.
- SET on 0xB03 with din_i=0x100 while hpm_event_i[0]=1 -> value becomes old|0x100, no increment that cycle.
- we_i with op WRITE to 0xC00 -> illegal_o=1, cycle unaffected; read 0x7FF -> illegal_o=1, dout_o=0; drop reset_ni mid-count -> all reads 0 immediately.
